approx_mul_pipe: RTL and testbench

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

---
 rtl/approx_mul_pkg.sv | 47 ++++
 rtl/apx_or_pair.sv | 28 ++
 rtl/approx_mul_pipe.sv | 182 ++++++++++++++++++
 tb/tb_approx_mul_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// -----------------------------------------------------------------------------
// approx_mul_pkg
// Shared definitions for the approximate multiplier pipeline.
//   params_legal() : legality check on W / APX_ROWS / TAG_W ranges.
//   apx_product()  : reference product. Rows below apx_rows are OR-compressed
//                    pairwise. The remaining rows are added exactly. The result
//                    is taken modulo 2^(2w).
// Optional feature elsewhere in the slice: APXM_PERF_CNT_EN (perf counters).
// -----------------------------------------------------------------------------
package approx_mul_pkg;

    localparam int MAX_W = 32;

    // W must be even and in 4..32. APX_ROWS must be even and in 0..W.
    // TAG_W must be at least 1.
    function automatic bit params_legal(input int w, input int apx_rows, input int tag_w);
        return (w >= 4) && (w <= MAX_W) && (w % 2 == 0) &&
               (apx_rows >= 0) && (apx_rows <= w) && (apx_rows % 2 == 0) &&
               (tag_w >= 1);
    endfunction

    // Operands are taken zero-extended to 32 bits. Only the low w bits are meaningful.
    function automatic logic [63:0] apx_product(input logic [31:0] a, input logic [31:0] b,
                                                input int apx_rows, input int w);
        logic [63:0] acc;
        logic [63:0] r_lo;
        logic [63:0] r_hi;
        acc = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r_lo = a[i] ? {32'd0, b} : 64'd0;
                if (i < apx_rows) begin
                    // apx_rows is even, so i+1 is still an approximated row.
                    if (i % 2 == 0) begin
                        r_hi = a[i+1] ? {32'd0, b} : 64'd0;
                        acc  = acc + ((r_lo | (r_hi << 1)) << i);
                    end
                end else begin
                    acc = acc + (r_lo << i);
                end
            end
        end
        // A shift by 64 yields 0. The mask is then all ones when w == 32.
        return acc & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

endpackage

// File: rtl/apx_or_pair.sv
// -----------------------------------------------------------------------------
// apx_or_pair
// OR-compresses two adjacent partial-product rows into one row of W+1 bits.
// The result is (a_lo ? b : 0) | ((a_hi ? b : 0) << 1).
//   a_lo : input, 1   -- multiplier bit of the even row
//   a_hi : input, 1   -- multiplier bit of the odd row
//   b    : input, W   -- multiplicand
//   row  : output, W+1 -- compressed row (not yet shifted to its pair weight)
// -----------------------------------------------------------------------------
module apx_or_pair #(
    parameter int W = 8
) (
    input  logic         a_lo,
    input  logic         a_hi,
    input  logic [W-1:0] b,
    output logic [W:0]   row
);

    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;

    assign r_lo = a_lo ? b : '0;
    assign r_hi = a_hi ? b : '0;

    // The OR replaces the adder. Overlapping bits lose their carry.
    assign row = {1'b0, r_lo} | {r_hi, 1'b0};

endmodule

// File: rtl/approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// approx_mul_pipe
// Two-stage valid/ready pipelined unsigned multiplier. The lowest APX_ROWS
// partial-product rows are OR-compressed pairwise. Setting exact=1 on a beat
// forces an exact product for that beat.
//   S1 registers one (W+2)-bit term per row pair, plus the tag and valid.
//   S2 registers the reduced 2W-bit sum, plus the tag and valid.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : input handshake
//   a, b (W), exact, in_tag   : operands, exact-mode select, sideband tag
//   out_valid/out_ready       : output handshake
//   p (2W), out_tag           : product and returned tag
//   cnt_clr, acc_cnt, apx_cnt : present only with APXM_PERF_CNT_EN defined.
//                               Saturating counts of accepted beats and of
//                               accepted non-exact beats.
// -----------------------------------------------------------------------------
import approx_mul_pkg::*;

module approx_mul_pipe #(
    parameter int W        = 8,
    parameter int APX_ROWS = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             exact,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic [TAG_W-1:0] out_tag
`ifdef APXM_PERF_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [31:0]      acc_cnt,
    output logic [31:0]      apx_cnt
`endif
);

    localparam int NP = W / 2;   // number of row pairs
    localparam int PW = W + 2;   // width of one exact pair sum

    if (!params_legal(W, APX_ROWS, TAG_W)) begin : g_bad_params
        $error("approx_mul_pipe: illegal W/APX_ROWS/TAG_W combination");
    end

    // Elaboration-time sanity check of the shared reference function.
    if (apx_product(32'd3, 32'd255, 2, 8) != 64'd511) begin : g_bad_ref
        $error("approx_mul_pkg::apx_product self-check failed");
    end

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic accept;

    // S2 can take new data when it is empty or its result leaves this cycle.
    // With S1 and S2 both full, S1 can still accept while S2 drains.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------ row pair generation
    // Pair k covers rows 2k and 2k+1 at weight 2^(2k). Exact pairs add the two
    // rows. Approximated pairs OR them, except when the beat requests exact mode.
    logic [NP-1:0][PW-1:0] pair_d;

    for (genvar k = 0; k < NP; k++) begin : g_pair
        logic [W-1:0]  r_lo;
        logic [W-1:0]  r_hi;
        logic [PW-1:0] exact_pair;

        assign r_lo       = a[2*k]   ? b : '0;
        assign r_hi       = a[2*k+1] ? b : '0;
        assign exact_pair = {2'b00, r_lo} + {1'b0, r_hi, 1'b0};

        if (k < APX_ROWS / 2) begin : g_apx
            logic [W:0] or_row;

            apx_or_pair #(.W(W)) u_or_pair (
                .a_lo (a[2*k]),
                .a_hi (a[2*k+1]),
                .b    (b),
                .row  (or_row)
            );

            assign pair_d[k] = exact ? exact_pair : {1'b0, or_row};
        end else begin : g_exact
            assign pair_d[k] = exact_pair;
        end
    end

    // ------------------------------------------------------------------ stage 1
    logic [NP-1:0][PW-1:0] s1_pair;
    logic [TAG_W-1:0]      s1_tag;

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples its pre-edge inputs, whatever order the blocks run in.
    // NOTE: the datapath registers are reset too. The reset value of p and
    // out_tag must be 0, and the cost is a few flops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pair  <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pair <= pair_d;
                s1_tag  <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------- reduction
    logic [2*W-1:0] sum_d;

    // NOTE: sum_d is given a default before the loop. No path leaves it
    // unassigned, so no latch is inferred.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NP; k++) begin
            sum_d = sum_d + ({{(2*W-PW){1'b0}}, s1_pair[k]} << (2 * k));
        end
    end

    // ------------------------------------------------------------------ stage 2
    logic [2*W-1:0]   s2_p;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_tag   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p   <= sum_d;
                s2_tag <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign p         = s2_p;
    assign out_tag   = s2_tag;

    // ------------------------------------------------------- perf counters
`ifdef APXM_PERF_CNT_EN
    // A clear on the same cycle as an increment takes priority.
    // Both counters stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            apx_cnt <= '0;
        end else if (cnt_clr) begin
            acc_cnt <= '0;
            apx_cnt <= '0;
        end else if (accept) begin
            if (acc_cnt != '1) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
            if (!exact && (apx_cnt != '1)) begin
                apx_cnt <= apx_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_mul_pipe
// Self-checking bench. Two instances are driven from the same stimulus:
//   u_dut2 : W=8, APX_ROWS=2
//   u_dut4 : W=8, APX_ROWS=4
// The model is a queue of accepted beats:
//   - in_ready is expected when fewer than two beats are held, or out_ready=1.
//   - out_valid is expected when the oldest beat has been held for 2 edges.
//   - The expected product is a*b for an exact beat, else apx_product().
// Covers APXM_PERF_CNT_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_approx_mul_pipe;
    import approx_mul_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       exact;
    logic [3:0] in_tag;
    logic       out_ready;

    logic        in_ready2, out_valid2, in_ready4, out_valid4;
    logic [15:0] p2, p4;
    logic [3:0]  out_tag2, out_tag4;

`ifdef APXM_PERF_CNT_EN
    logic        cnt_clr;
    logic [31:0] acc_cnt2, apx_cnt2, acc_cnt4, apx_cnt4;
`endif

    approx_mul_pipe #(.W(8), .APX_ROWS(2), .TAG_W(4)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .in_tag    (in_tag),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .p         (p2),
        .out_tag   (out_tag2)
`ifdef APXM_PERF_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .acc_cnt   (acc_cnt2),
        .apx_cnt   (apx_cnt2)
`endif
    );

    approx_mul_pipe #(.W(8), .APX_ROWS(4), .TAG_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .in_tag    (in_tag),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .p         (p4),
        .out_tag   (out_tag4)
`ifdef APXM_PERF_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .acc_cnt   (acc_cnt4),
        .apx_cnt   (apx_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ex;
        logic [3:0] tag;
        int         age;
    } beat_t;

    beat_t       q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_p2, last_p4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_p(input beat_t x, input int rows);
        logic [63:0] full;
        if (x.ex || rows == 0) begin
            return 16'(x.a) * 16'(x.b);
        end
        full = apx_product({24'd0, x.a}, {24'd0, x.b}, rows, 8);
        return full[15:0];
    endfunction

    // One clock cycle. Entered and left at posedge+1. Outputs are checked at
    // the negedge, before the edge that acts on this cycle's handshake.
    task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ie, input logic [3:0] it, input logic ordy);
        logic  exp_ready;
        logic  exp_valid;
        beat_t nb;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        exact     = ie;
        in_tag    = it;
        out_ready = ordy;
        @(negedge clk);
        exp_ready = (q.size() < 2) || ordy;
        exp_valid = (q.size() > 0) && (q[0].age >= 2);
        check("in_ready_r2", in_ready2, exp_ready);
        check("in_ready_r4", in_ready4, exp_ready);
        check("out_valid_r2", out_valid2, exp_valid);
        check("out_valid_r4", out_valid4, exp_valid);
        if (exp_valid) begin
            check("p_r2", p2, model_p(q[0], 2));
            check("p_r4", p4, model_p(q[0], 4));
            check("tag_r2", out_tag2, q[0].tag);
            check("tag_r4", out_tag4, q[0].tag);
        end
        last_p2 = p2;
        last_p4 = p4;
        @(posedge clk);
        if (exp_valid && ordy) begin
            void'(q.pop_front());
        end
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (iv && exp_ready) begin
            nb.a   = ia;
            nb.b   = ib;
            nb.ex  = ie;
            nb.tag = it;
            nb.age = 1;
            q.push_back(nb);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, ordy);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] tag;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        exact     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
`ifdef APXM_PERF_CNT_EN
        cnt_clr   = 1'b0;
`endif
        last_p2   = '0;
        last_p4   = '0;

        // Values held during reset
        #3;
        check("rst_out_valid", out_valid2, 1'b0);
        check("rst_in_ready", in_ready2, 1'b1);
        check("rst_p", p2, 16'd0);
        check("rst_out_tag", out_tag2, 4'd0);
        check("rst_p_r4", p4, 16'd0);

        // Release between edges. The very next rising edge must accept a beat.
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases with known products
        cycle(1'b1, 8'd3, 8'd255, 1'b0, 4'd1, 1'b1);
        cycle(1'b1, 8'd3, 8'd255, 1'b1, 4'd2, 1'b1);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 4'd3, 1'b1);
        check("dir_3x255_apx", last_p2, 16'd511);
        cycle(1'b1, 8'h10, 8'h0F, 1'b0, 4'd4, 1'b1);
        check("dir_3x255_exact", last_p2, 16'd765);
        idle(1'b1);
        idle(1'b1);
        check("dir_10x0f_r2", last_p2, 16'h00F0);
        check("dir_10x0f_r4", last_p4, 16'h00F0);
        idle(1'b1);

        // Back-to-back stream of 16 beats, tags 0..15
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 4'(i), 1'b1);
        end
        repeat (3) idle(1'b1);

        // Output stalled for 5 cycles while input keeps offering beats
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 4'(i + 8), 1'b0);
        end
        check("stall_held", q.size(), 2);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 4'(i + 13), 1'b1);
        end
        repeat (3) idle(1'b1);

        // Random valid/ready pattern
        tag = 4'd0;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0, tag, $urandom_range(0, 2) != 0);
            tag = tag + 4'd1;
        end
        repeat (4) idle(1'b1);
        check("drain_empty", q.size(), 0);

        // Reset asserted with two beats in flight
        cycle(1'b1, 8'd7, 8'd9, 1'b0, 4'd5, 1'b0);
        cycle(1'b1, 8'd11, 8'd13, 1'b0, 4'd6, 1'b0);
        in_valid = 1'b0;
        check("inflight_before_rst", q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid2, 1'b0);
        check("midrst_out_valid_r4", out_valid4, 1'b0);
        check("midrst_in_ready", in_ready2, 1'b1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) idle(1'b1);

`ifdef APXM_PERF_CNT_EN
        // Ten accepted beats, four of them exact
        cnt_clr = 1'b1;
        idle(1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), i < 4, 4'(i), 1'b1);
        end
        repeat (3) idle(1'b1);
        check("acc_cnt", acc_cnt2, 32'd10);
        check("apx_cnt", apx_cnt2, 32'd6);
        check("acc_cnt_r4", acc_cnt4, 32'd10);
        // A clear on the same cycle as an accept leaves both counters at 0
        cnt_clr = 1'b1;
        cycle(1'b1, 8'd5, 8'd6, 1'b0, 4'd9, 1'b1);
        cnt_clr = 1'b0;
        check("acc_cnt_clr", acc_cnt2, 32'd0);
        check("apx_cnt_clr", apx_cnt2, 32'd0);
        repeat (3) idle(1'b1);
`endif

        check("final_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
